// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
// Feeds the CLB fle/ble4 configuration-chain head from a byte stream.
// Bytes arrive over a valid/ready handshake, are serialised MSB-first and
// shifted into the chain one bit per prog_clk cycle with ccff_shift_en high.
// A load completes once exactly CHAIN_LEN bits have moved into the chain.
//
// Optional build macro CCFF_READBACK_CHECK_EN adds a loopback readback check:
// a CRC-8 (poly 0x07, init 0x00) of the bits returned on ccff_tail during a
// load is compared with the CRC-8 of the bits shifted in by the previous
// completed load, and the verdict is reported on readback_valid and
// readback_mismatch.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 68,  // total chain bits, >= 1
  parameter int CNT_W     = 16   // bit counter width, CHAIN_LEN < 2**CNT_W
) (
  input  logic             prog_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             ccff_head,
  output logic             ccff_shift_en,
  input  logic             ccff_tail,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
`ifdef CCFF_READBACK_CHECK_EN
  ,
  output logic             readback_mismatch,
  output logic             readback_valid
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       shreg_q;      // byte being serialised, bit 7 goes out next
  logic [3:0]       byte_cnt_q;   // bits of the current byte still to shift
  logic [CNT_W-1:0] bit_count_q;  // bits shifted so far in this load
  logic [CNT_W-1:0] remaining;
  logic [3:0]       first_cnt;
  logic             start_ok;
  logic             accept;
  logic             last_bit;

  // abort wins over a simultaneous start, so a start only counts without it
  assign start_ok  = start && !abort;
  // a byte is taken only in LOAD and never in an abort cycle
  assign accept    = (state_q == S_LOAD) && !abort && cfg_valid;
  // the shift happening this cycle is the final chain bit
  assign last_bit  = (bit_count_q == CNT_W'(CHAIN_LEN - 1));
  // the final byte may be partial: only its top (CHAIN_LEN mod 8) bits go out
  assign remaining = CNT_W'(CHAIN_LEN) - bit_count_q;
  assign first_cnt = (remaining >= CNT_W'(8)) ? 4'd8 : remaining[3:0];

  // State register.
  always_ff @(posedge prog_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the design samples pre-edge values regardless of block ordering.
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (abort)          state_d = S_IDLE;
        else if (cfg_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)                  state_d = S_IDLE;
        else if (last_bit)          state_d = S_DONE;
        else if (byte_cnt_q == 4'd1) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; cfg_ready alone also sees abort.
  always_comb begin
    cfg_ready     = 1'b0;
    ccff_head     = 1'b0;
    ccff_shift_en = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      S_LOAD: begin
        cfg_ready = !abort;
        busy      = 1'b1;
      end
      S_SHIFT: begin
        ccff_head     = shreg_q[7];
        ccff_shift_en = 1'b1;
        busy          = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Serialiser datapath: byte latch, MSB-first shift and bit counters.
  always_ff @(posedge prog_clk) begin
    // NOTE: only this block's own registers are reset; the downstream chain
    // flops keep whatever they hold and a full reload overwrites them.
    if (reset) begin
      shreg_q     <= 8'h00;
      byte_cnt_q  <= 4'd0;
      bit_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) bit_count_q <= '0;
        end
        S_LOAD: begin
          if (accept) begin
            shreg_q    <= cfg_data;
            byte_cnt_q <= first_cnt;
          end
        end
        S_SHIFT: begin
          // the chain moves on an abort cycle too, so the count follows it
          shreg_q     <= {shreg_q[6:0], 1'b0};
          bit_count_q <= bit_count_q + CNT_W'(1);
          byte_cnt_q  <= byte_cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bit_count = bit_count_q;

`ifdef CCFF_READBACK_CHECK_EN
  // Serial CRC-8, polynomial x^8 + x^2 + x + 1, one input bit per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       din);
    logic fb;
    fb        = crc[7] ^ din;
    crc8_step = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  logic [7:0] head_crc_q;  // CRC of bits sent into the head this load
  logic [7:0] tail_crc_q;  // CRC of bits returned from the tail this load
  logic [7:0] ref_crc_q;   // head CRC of the last completed load
  logic       have_ref_q;  // a completed load exists since reset
  logic [7:0] head_crc_nxt;
  logic [7:0] tail_crc_nxt;
  logic       entering_done;

  assign head_crc_nxt  = crc8_step(head_crc_q, ccff_head);
  assign tail_crc_nxt  = crc8_step(tail_crc_q, ccff_tail);
  assign entering_done = (state_q == S_SHIFT) && (state_d == S_DONE);

  // Readback CRCs and verdict, judged on the edge that enters DONE.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      head_crc_q        <= 8'h00;
      tail_crc_q        <= 8'h00;
      ref_crc_q         <= 8'h00;
      have_ref_q        <= 1'b0;
      readback_valid    <= 1'b0;
      readback_mismatch <= 1'b0;
    end else if (((state_q == S_IDLE) || (state_q == S_DONE)) && start_ok) begin
      head_crc_q        <= 8'h00;
      tail_crc_q        <= 8'h00;
      readback_valid    <= 1'b0;
      readback_mismatch <= 1'b0;
    end else if (ccff_shift_en) begin
      head_crc_q <= head_crc_nxt;
      tail_crc_q <= tail_crc_nxt;
      if (entering_done) begin
        ref_crc_q         <= head_crc_nxt;
        have_ref_q        <= 1'b1;
        readback_valid    <= have_ref_q;
        readback_mismatch <= have_ref_q && (tail_crc_nxt != ref_crc_q);
      end
    end
  end
`else
  // Chain tail return is only consumed by the readback check.
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain feeder sitting directly upstream of the CLB's fle/ble4 configuration-chain head input.
- Accepts the bitstream as bytes over a valid/ready interface, serialises it MSB-first, and shifts it into the chain with a per-bit shift enable.
- Signals completion once exactly CHAIN_LEN bits have been shifted.
- Runs on the programming clock, alongside the tiles' own configuration flops.

Parameters:
- CHAIN_LEN, 68, total configuration bits in the downstream chain (4 FLEs x 17 bits). Must be >= 1.
- CNT_W, 16, width of the bit counter. Requires CHAIN_LEN < 2**CNT_W.

Ports:
- prog_clk  input  1  programming clock; all state is updated on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load. Accepted only in IDLE or DONE.
- abort  input  1  cancels a load in progress.
- cfg_data  input  8  bitstream byte; bit 7 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial data into the chain head.
- ccff_shift_en  output  1  chain shift enable (prog_clk gate); exactly one chain bit moves per cycle while it is high.
- ccff_tail  input  1  chain tail return. Used only by the optional feature.
- busy  output  1  high in LOAD or SHIFT.
- done  output  1  high in DONE.
- bit_count  output  CNT_W  number of bits shifted so far in this load.

Behaviour:
- States: IDLE, LOAD, SHIFT, DONE. All outputs decode from registered state, shift register and counters, so there are no combinational input-to-output paths except cfg_ready.
- Reset:
  - state=IDLE, bit_count=0, byte-bit counter=0, shift register=0.
  - cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0.
  - Chain contents are not reset.
- IDLE / DONE:
  - On start: go to LOAD and clear bit_count.
  - DONE holds done=1 until the next start or reset.
- LOAD:
  - cfg_ready=1.
  - On cfg_valid: latch cfg_data into the 8-bit shift register, set the byte-bit counter to min(8, CHAIN_LEN-bit_count), and go to SHIFT.
  - No cfg_valid: stay in LOAD; a stall has no timeout.
- SHIFT:
  - cfg_ready=0, ccff_shift_en=1, ccff_head=shreg[7].
  - Each cycle: shift the register left (zero fill), increment bit_count, decrement the byte-bit counter.
  - After the cycle in which bit_count becomes CHAIN_LEN: go to DONE.
  - Else, once the byte-bit counter reaches 0: go to LOAD.
- Throughput: one byte per 9 cycles (1 accept cycle + 8 shift cycles).
- Final partial byte: only the top (CHAIN_LEN mod 8) bits are shifted; the remaining low bits are discarded.
- abort:
  - In LOAD or SHIFT: state becomes IDLE on the next edge, and ccff_shift_en=0 from that edge on.
  - bit_count holds its value until the next start.
  - A simultaneous abort and cfg_valid in LOAD gives abort priority; the byte is not accepted.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: ignored (abort wins).
- reset mid-load: immediate return to IDLE. The chain is left partially loaded and must be reloaded.

Optional Feature:
- Macro CCFF_READBACK_CHECK_EN.
- With the macro defined:
  - Adds output readback_mismatch (1 bit) and output readback_valid (1 bit).
  - While ccff_shift_en=1, ccff_tail is compared against a running CRC-8 (poly 0x07, init 0x00) of the bits shifted in during the previous load. The check uses a second CRC of ccff_tail bits accumulated over the same cycles.
  - On entry to DONE: readback_valid=1, and readback_mismatch=1 iff the two CRCs differ.
  - The first load after reset reports readback_valid=0.
  - Both outputs are cleared on start or reset.
- Without the macro: neither port exists, ccff_tail is unused, and no CRC logic is present.

Test Plan:
- Reset, then start, then bytes 0xA5, 0x3C, 0xFF, ..., 9 bytes total with CHAIN_LEN=68 -> ccff_head sequence is 1,0,1,0,0,1,0,1,0,0,1,1,... with ccff_shift_en high for exactly 68 cycles. done rises the cycle after bit 68, bit_count=68, and the 9th byte contributes only bits 7..4.
- CHAIN_LEN=17, bytes 0xFF, 0x00, 0x80 -> 17 shifts, the last byte shifts a single 1, done=1, and no fourth cfg_ready is asserted.
- cfg_valid held low for 20 cycles in LOAD -> cfg_ready stays 1, ccff_shift_en stays 0, and the bit_count value is frozen.
- abort in the 4th SHIFT cycle of the 2nd byte -> IDLE next cycle, ccff_shift_en=0, bit_count=12. A subsequent start clears bit_count to 0.
- start pulsed during SHIFT -> no effect: the bit sequence and the cycle in which done rises are identical to the undisturbed run.
- With CCFF_READBACK_CHECK_EN, loopback chain model of length CHAIN_LEN: load the pattern twice -> 2nd load gives readback_valid=1, readback_mismatch=0. Flip one tail bit in the model -> readback_mismatch=1.
